// File: rtl/mem_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
// The port enum doubles as the bit index into the request and grant vectors.
package mem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } mem_port_e;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two core request ports plus the RAM pins owned by the arbiter.
// The master modport is the core side, slave is the arbiter, mem is the RAM.
interface ram_arbiter_if #(
  parameter int DATA_W = mem_pkg::DATA_W
);

  logic              m0_req;
  logic [DATA_W-1:0] m0_addr;
  logic              m0_ready;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [DATA_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ready;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [DATA_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport master (
    output m0_req, m0_addr,
    input  m0_ready, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ready, m1_rvalid, m1_rdata
  );

  modport slave (
    input  m0_req, m0_addr,
    output m0_ready, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ready, m1_rvalid, m1_rdata,
    output ram_addr, ram_we, ram_data_in,
    input  ram_data_out
  );

  modport mem (
    input  ram_addr, ram_we, ram_data_in,
    output ram_data_out
  );

endinterface

// File: rtl/ram_arb_prio.sv
// Fixed-priority grant (load/store wins) with a saturating starvation counter
// that hands the fetch port one grant after STARVE_LIMIT consecutive losses.
module ram_arb_prio #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  import mem_pkg::*;

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_next;
  logic             w_starved;

  assign w_starved = (r_starve_cnt == LIMIT);

  // Grants are held off during reset so nothing can complete or write.
  always_comb begin
    o_gnt = '0;
    if (!rst) begin
      if (i_req[PORT_LS] && !(i_req[PORT_IF] && w_starved)) begin
        o_gnt[PORT_LS] = 1'b1;
      end else if (i_req[PORT_IF]) begin
        o_gnt[PORT_IF] = 1'b1;
      end
    end
  end

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (o_gnt[PORT_IF] || !i_req[PORT_IF]) begin
      w_starve_next = '0;
    end else if (o_gnt[PORT_LS] && !w_starved) begin
      w_starve_next = r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_next;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch (port 0, read-only)
// and load/store (port 1); drives every RAM pin and registers read responses.
module ram_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_rd1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_rvalid0;
  logic              r_rvalid1;

  assign w_req[mem_pkg::PORT_IF] = bus.m0_req;
  assign w_req[mem_pkg::PORT_LS] = bus.m1_req;

  ram_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign bus.m0_ready = w_gnt[mem_pkg::PORT_IF];
  assign bus.m1_ready = w_gnt[mem_pkg::PORT_LS];

  // Idle RAM pins park at zero so the bus is quiet when nobody is granted.
  always_comb begin
    bus.ram_addr    = '0;
    bus.ram_we      = 1'b0;
    bus.ram_data_in = '0;
    if (w_gnt[mem_pkg::PORT_LS]) begin
      bus.ram_addr    = bus.m1_addr;
      bus.ram_we      = bus.m1_we;
      bus.ram_data_in = bus.m1_wdata;
    end else if (w_gnt[mem_pkg::PORT_IF]) begin
      bus.ram_addr = bus.m0_addr;
    end
  end

  assign w_rd1 = w_gnt[mem_pkg::PORT_LS] && !bus.m1_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rdata0  <= '0;
    end else begin
      r_rvalid0 <= w_gnt[mem_pkg::PORT_IF];
      if (w_gnt[mem_pkg::PORT_IF]) begin
        r_rdata0 <= bus.ram_data_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid1 <= 1'b0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid1 <= w_rd1;
      if (w_rd1) begin
        r_rdata1 <= bus.ram_data_out;
      end
    end
  end

  assign bus.m0_rvalid = r_rvalid0;
  assign bus.m0_rdata  = r_rdata0;
  assign bus.m1_rvalid = r_rvalid1;
  assign bus.m1_rdata  = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 128-word RAM model; read data is
// checked by a monitor against a per-port expectation queue.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] mem [0:127];
  logic [31:0] m1_read_exp;

  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_W(32)) bus ();

  ram_arbiter #(
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr[6:0]] <= bus.ram_data_in;
  end
  assign bus.ram_data_out = mem[bus.ram_addr[6:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard monitor: every rvalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m0_rvalid) begin
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL m0_rvalid_unexpected: got 1 expected 0");
        end else check("m0_rdata", bus.m0_rdata, exp_q0.pop_front());
      end
      if (bus.m1_rvalid) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL m1_rvalid_unexpected: got 1 expected 0");
        end else check("m1_rdata", bus.m1_rdata, exp_q1.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bus.m0_ready && bus.m1_ready) begin
      checks++; errors++;
      $display("FAIL ready_exclusive: got 11 expected not both");
    end
  end

  task automatic m1_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp);
    int n = 0;
    bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    #1;
    while (!bus.m1_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("m1_ready", {31'b0, bus.m1_ready}, 32'd1);
    check("m1_ram_we", {31'b0, bus.ram_we}, {31'b0, we});
    if (!we) exp_q1.push_back(exp);
    @(negedge clk);
    bus.m1_req = 1'b0; bus.m1_we = 1'b0;
    check("m1_rvalid_lat", {31'b0, bus.m1_rvalid}, {31'b0, !we});
  endtask

  task automatic m0_read(input logic [31:0] addr, input logic [31:0] exp);
    int n = 0;
    bus.m0_req = 1'b1; bus.m0_addr = addr;
    #1;
    while (!bus.m0_ready && n < 20) begin @(negedge clk); #1; n++; end
    check("m0_ready", {31'b0, bus.m0_ready}, 32'd1);
    exp_q0.push_back(exp);
    @(negedge clk);
    bus.m0_req = 1'b0;
    check("m0_rvalid_lat", {31'b0, bus.m0_rvalid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pattern;
    pattern = 10'b0111101111;  // bit i = 1 when port 1 wins cycle i
    rst = 1'b1;
    bus.m0_req = 1'b0; bus.m0_addr = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    @(negedge clk);
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'd4; bus.m1_wdata = 32'h55;
    #1;
    check("rst_m1_ready", {31'b0, bus.m1_ready}, 32'd0);
    check("rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
    check("rst_rvalids", {30'b0, bus.m0_rvalid, bus.m1_rvalid}, 32'd0);
    check("rst_m0_rdata", bus.m0_rdata, 32'd0);
    check("rst_m1_rdata", bus.m1_rdata, 32'd0);
    @(negedge clk);
    bus.m1_req = 1'b0; bus.m1_we = 1'b0;
    rst = 1'b0;

    // Write then read back through port 1
    m1_xfer(1'b1, 32'd4, 32'hDEADBEEF, 32'h0);
    m1_xfer(1'b0, 32'd4, 32'h0, 32'hDEADBEEF);

    // Write immediately followed by a fetch of the same word
    m1_xfer(1'b1, 32'd8, 32'h1, 32'h0);
    m0_read(32'd8, 32'h1);

    // Simultaneous reads: port 1 first, port 0 the following cycle
    bus.m0_req = 1'b1; bus.m0_addr = 32'd4;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'd8;
    #1;
    check("both_m1_ready", {31'b0, bus.m1_ready}, 32'd1);
    check("both_m0_ready", {31'b0, bus.m0_ready}, 32'd0);
    check("both_ram_addr", bus.ram_addr, 32'd8);
    exp_q1.push_back(32'h1);
    @(negedge clk);
    bus.m1_req = 1'b0;
    #1;
    check("both2_m0_ready", {31'b0, bus.m0_ready}, 32'd1);
    check("both2_rvalids", {30'b0, bus.m0_rvalid, bus.m1_rvalid}, 32'd1);
    exp_q0.push_back(32'hDEADBEEF);
    @(negedge clk);
    bus.m0_req = 1'b0;
    check("both3_rvalids", {30'b0, bus.m0_rvalid, bus.m1_rvalid}, 32'd2);

    // Continuous contention: port 0 wins every fifth cycle
    bus.m0_req = 1'b1; bus.m0_addr = 32'd4;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'd8;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("starve_gnt%0d", i), {30'b0, bus.m1_ready, bus.m0_ready},
            pattern[i] ? 32'd2 : 32'd1);
      if (pattern[i]) exp_q1.push_back(32'h1);
      else exp_q0.push_back(32'hDEADBEEF);
      @(negedge clk);
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;

    // Idle bus
    @(negedge clk);
    check("idle_ram_we", {31'b0, bus.ram_we}, 32'd0);
    check("idle_ram_addr", bus.ram_addr, 32'd0);
    check("idle_ram_data_in", bus.ram_data_in, 32'd0);
    check("idle_rvalids", {30'b0, bus.m0_rvalid, bus.m1_rvalid}, 32'd0);

    // Reset lands while a port-1 write is granted
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'd8; bus.m1_wdata = 32'hBAD0BAD0;
    #1;
    check("pre_rst_ram_we", {31'b0, bus.ram_we}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
    check("mid_rst_m1_ready", {31'b0, bus.m1_ready}, 32'd0);
    @(negedge clk);
    check("rst_rvalids2", {30'b0, bus.m0_rvalid, bus.m1_rvalid}, 32'd0);
    check("rst_rdata1", bus.m1_rdata, 32'd0);
    bus.m1_req = 1'b0; bus.m1_we = 1'b0;
    rst = 1'b0;
    m1_read_exp = mem[8];
    check("mem8_kept", m1_read_exp, 32'h1);

    m1_xfer(1'b1, 32'd4, 32'hDEADBEEF, 32'h0);
    m1_xfer(1'b0, 32'd4, 32'h0, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    check("q_drained", exp_q0.size() + exp_q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
